// File: rtl/bus_seq_pkg.sv
// Shared types and default sizing for the bus transfer sequencer.
package bus_seq_pkg;

    localparam int unsigned DEFAULT_NUM_REGS   = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_RELEASE = 2'd3
    } bus_seq_state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Index + enable to one-hot decoder; indices beyond NUM_OUT decode to all-zero.
module onehot_decoder
    import bus_seq_pkg::*;
#(
    parameter int unsigned NUM_OUT = DEFAULT_NUM_REGS,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [IDX_W-1:0]   i_idx,
    input  logic               i_en,
    output logic [NUM_OUT-1:0] o_onehot_c
);

    // Combinational decode of the selected index.
    always_comb begin
        o_onehot_c = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (i_en && (i_idx == IDX_W'(i))) begin
                o_onehot_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Bus transfer sequencer: accepts one move command at a time and sequences
// source drive, destination capture and bus release on the shared data bus.
// Optional immediate path enabled by defining BUS_SEQ_IMM_EN; without it the
// immediate outputs are tied low and immediate commands are rejected.
module bus_transfer_sequencer
    import bus_seq_pkg::*;
#(
    parameter  int unsigned NUM_REGS   = DEFAULT_NUM_REGS,
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  register_clock,
    input  logic                  register_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [IDX_W-1:0]      cmd_src,
    input  logic [IDX_W-1:0]      cmd_dst,
    input  logic                  cmd_imm_sel,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [NUM_REGS-1:0]   reg_out_en,
    output logic [NUM_REGS-1:0]   reg_in_en,
    output logic                  imm_out_en,
    output logic [DATA_WIDTH-1:0] imm_data,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);

`ifdef BUS_SEQ_IMM_EN
    localparam logic LP_IMM_EN = 1'b1;
`else
    localparam logic LP_IMM_EN = 1'b0;
`endif

    localparam logic [IDX_W:0] LP_NUM_REGS = (IDX_W+1)'(NUM_REGS);

    // State and held command
    bus_seq_state_e     r_state;
    logic [IDX_W-1:0]   r_src;
    logic [IDX_W-1:0]   r_dst;
    logic               r_imm_sel;

    // Registered outputs
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [NUM_REGS-1:0] r_reg_out_en;
    logic [NUM_REGS-1:0] r_reg_in_en;

    // Next-state / next-output values
    bus_seq_state_e     w_state_nxt;
    logic               w_accept;
    logic               w_cmd_bad;
    logic [IDX_W-1:0]   w_src_nxt;
    logic [IDX_W-1:0]   w_dst_nxt;
    logic               w_imm_sel_nxt;
    logic               w_src_phase;
    logic               w_reg_drv_nxt;
    logic               w_cap_nxt;
    logic               w_cmd_ready_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic [NUM_REGS-1:0] w_reg_out_en_nxt;
    logic [NUM_REGS-1:0] w_reg_in_en_nxt;

    // Command validation against the register count and build options.
    always_comb begin
        w_cmd_bad = 1'b0;
        if ({1'b0, cmd_dst} >= LP_NUM_REGS) begin
            w_cmd_bad = 1'b1;
        end
        if (!cmd_imm_sel && ({1'b0, cmd_src} >= LP_NUM_REGS)) begin
            w_cmd_bad = 1'b1;
        end
        if (cmd_imm_sel && !LP_IMM_EN) begin
            w_cmd_bad = 1'b1;
        end
    end

    // Next-state and next-output logic; outputs are decoded from the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    if (w_cmd_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE:   w_state_nxt = ST_LATCH;
            ST_LATCH:   w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase

        w_src_nxt     = w_accept ? cmd_src     : r_src;
        w_dst_nxt     = w_accept ? cmd_dst     : r_dst;
        w_imm_sel_nxt = w_accept ? cmd_imm_sel : r_imm_sel;

        w_src_phase     = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_LATCH);
        w_reg_drv_nxt   = w_src_phase && !w_imm_sel_nxt;
        // A register moved onto itself is driven but never captured.
        w_cap_nxt       = (w_state_nxt == ST_LATCH)
                          && !(!w_imm_sel_nxt && (w_src_nxt == w_dst_nxt));
        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_done_nxt      = (w_state_nxt == ST_RELEASE);
    end

    onehot_decoder #(
        .NUM_OUT (NUM_REGS),
        .IDX_W   (IDX_W)
    ) u_src_dec (
        .i_idx      (w_src_nxt),
        .i_en       (w_reg_drv_nxt),
        .o_onehot_c (w_reg_out_en_nxt)
    );

    onehot_decoder #(
        .NUM_OUT (NUM_REGS),
        .IDX_W   (IDX_W)
    ) u_dst_dec (
        .i_idx      (w_dst_nxt),
        .i_en       (w_cap_nxt),
        .o_onehot_c (w_reg_in_en_nxt)
    );

    // State, held command and registered outputs.
    always_ff @(posedge register_clock) begin
        if (!register_reset_n) begin
            r_state      <= ST_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_imm_sel    <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_reg_out_en <= '0;
            r_reg_in_en  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_src        <= w_src_nxt;
            r_dst        <= w_dst_nxt;
            r_imm_sel    <= w_imm_sel_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_reg_out_en <= w_reg_out_en_nxt;
            r_reg_in_en  <= w_reg_in_en_nxt;
        end
    end

`ifdef BUS_SEQ_IMM_EN
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_imm_out_en;
    logic [DATA_WIDTH-1:0] r_imm_data;
    logic [DATA_WIDTH-1:0] w_imm_nxt;
    logic                  w_imm_drv_nxt;

    assign w_imm_nxt     = w_accept ? cmd_imm : r_imm;
    assign w_imm_drv_nxt = w_src_phase && w_imm_sel_nxt;

    // Immediate holding register and registered immediate driver.
    always_ff @(posedge register_clock) begin
        if (!register_reset_n) begin
            r_imm        <= '0;
            r_imm_out_en <= 1'b0;
            r_imm_data   <= '0;
        end else begin
            r_imm        <= w_imm_nxt;
            r_imm_out_en <= w_imm_drv_nxt;
            r_imm_data   <= w_imm_drv_nxt ? w_imm_nxt : '0;
        end
    end

    assign imm_out_en = r_imm_out_en;
    assign imm_data   = r_imm_data;
`else
    logic w_unused_imm;

    assign w_unused_imm = ^cmd_imm;
    assign imm_out_en   = 1'b0;
    assign imm_data     = '0;
`endif

    assign cmd_ready  = r_cmd_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign reg_out_en = r_reg_out_en;
    assign reg_in_en  = r_reg_in_en;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer: a 4-register instance with a
// small register-file model, plus a 3-register instance for range rejection.
module tb_bus_transfer_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_src;
    logic [1:0]  cmd_dst;
    logic        cmd_imm_sel;
    logic [15:0] cmd_imm;

    logic        ready4, busy4, done4, err4, imm_oe4;
    logic [3:0]  out_en4, in_en4;
    logic [15:0] imm_data4;

    logic        ready3, busy3, done3, err3, imm_oe3;
    logic [2:0]  out_en3, in_en3;
    logic [15:0] imm_data3;

    // Status vectors: {ready, busy, done, err, imm_out_en, reg_out_en, reg_in_en}
    logic [12:0] st4;
    logic [10:0] st3;
    assign st4 = {ready4, busy4, done4, err4, imm_oe4, out_en4, in_en4};
    assign st3 = {ready3, busy3, done3, err3, imm_oe3, out_en3, in_en3};

    int n_checks = 0;
    int n_pass   = 0;

    bus_transfer_sequencer #(.NUM_REGS(4), .DATA_WIDTH(16)) u_dut4 (
        .register_clock   (clk),
        .register_reset_n (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (ready4),
        .cmd_src          (cmd_src),
        .cmd_dst          (cmd_dst),
        .cmd_imm_sel      (cmd_imm_sel),
        .cmd_imm          (cmd_imm),
        .reg_out_en       (out_en4),
        .reg_in_en        (in_en4),
        .imm_out_en       (imm_oe4),
        .imm_data         (imm_data4),
        .done             (done4),
        .err              (err4),
        .busy             (busy4)
    );

    bus_transfer_sequencer #(.NUM_REGS(3), .DATA_WIDTH(16)) u_dut3 (
        .register_clock   (clk),
        .register_reset_n (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (ready3),
        .cmd_src          (cmd_src),
        .cmd_dst          (cmd_dst),
        .cmd_imm_sel      (cmd_imm_sel),
        .cmd_imm          (cmd_imm),
        .reg_out_en       (out_en3),
        .reg_in_en        (in_en3),
        .imm_out_en       (imm_oe3),
        .imm_data         (imm_data3),
        .done             (done3),
        .err              (err3),
        .busy             (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model driven by the 4-register instance's strobes.
    logic [15:0] model_regs [4] = '{16'hA5A5, 16'h1234, 16'h0000, 16'h5678};
    logic [15:0] bus;

    always_comb begin
        bus = 16'h0000;
        if (imm_oe4) bus = imm_data4;
        for (int i = 0; i < 4; i++) begin
            if (out_en4[i]) bus = model_regs[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (in_en4[i]) model_regs[i] <= bus;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] src, input logic [1:0] dst,
                         input logic imm_sel, input logic [15:0] imm);
        cmd_valid   = 1'b1;
        cmd_src     = src;
        cmd_dst     = dst;
        cmd_imm_sel = imm_sel;
        cmd_imm     = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_src = 2'd0; cmd_dst = 2'd0; cmd_imm_sel = 1'b0; cmd_imm = 16'h0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (st4 !== 13'b1_0_0_0_0_0000_0000) $display("FAIL reset_st4: got %b want %b", st4, 13'b1_0_0_0_0_0000_0000);
        else n_pass++;
        n_checks++;
        if (imm_data4 !== 16'h0000) $display("FAIL reset_imm_data4: got %h want 0000", imm_data4);
        else n_pass++;
        n_checks++;
        if (st3 !== 11'b1_0_0_0_0_000_000) $display("FAIL reset_st3: got %b want %b", st3, 11'b1_0_0_0_0_000_000);
        else n_pass++;
        n_checks++;
        if (imm_data3 !== 16'h0000) $display("FAIL reset_imm_data3: got %h want 0000", imm_data3);
        else n_pass++;
    endtask

    task automatic test_reg_move();
        issue(2'd1, 2'd2, 1'b0, 16'h0);
        step();
        // Drop valid and scramble the command inputs; the held command must win.
        cmd_valid = 1'b0; cmd_src = 2'd3; cmd_dst = 2'd0;
        n_checks++;
        if (st4 !== 13'b0_1_0_0_0_0010_0000) $display("FAIL move_n1: got %b want %b", st4, 13'b0_1_0_0_0_0010_0000);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_0_0_0_0010_0100) $display("FAIL move_n2: got %b want %b", st4, 13'b0_1_0_0_0_0010_0100);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_1_0_0_0000_0000) $display("FAIL move_n3: got %b want %b", st4, 13'b0_1_1_0_0_0000_0000);
        else n_pass++;
        n_checks++;
        if (model_regs[2] !== 16'h1234) $display("FAIL move_r2_value: got %h want 1234", model_regs[2]);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b1_0_0_0_0_0000_0000) $display("FAIL move_n4: got %b want %b", st4, 13'b1_0_0_0_0_0000_0000);
        else n_pass++;
    endtask

    task automatic test_imm();
        issue(2'd0, 2'd3, 1'b1, 16'hBEEF);
        step();
        cmd_valid = 1'b0; cmd_imm_sel = 1'b0; cmd_imm = 16'h0;
`ifdef BUS_SEQ_IMM_EN
        n_checks++;
        if (st4 !== 13'b0_1_0_0_1_0000_0000) $display("FAIL imm_n1: got %b want %b", st4, 13'b0_1_0_0_1_0000_0000);
        else n_pass++;
        n_checks++;
        if (imm_data4 !== 16'hBEEF) $display("FAIL imm_data_n1: got %h want beef", imm_data4);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_0_0_1_0000_1000) $display("FAIL imm_n2: got %b want %b", st4, 13'b0_1_0_0_1_0000_1000);
        else n_pass++;
        n_checks++;
        if (imm_data4 !== 16'hBEEF) $display("FAIL imm_data_n2: got %h want beef", imm_data4);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_1_0_0_0000_0000) $display("FAIL imm_n3: got %b want %b", st4, 13'b0_1_1_0_0_0000_0000);
        else n_pass++;
        n_checks++;
        if (model_regs[3] !== 16'hBEEF) $display("FAIL imm_r3_value: got %h want beef", model_regs[3]);
        else n_pass++;
        step();
`else
        n_checks++;
        if (st4 !== 13'b1_0_0_1_0_0000_0000) $display("FAIL imm_rej_n1: got %b want %b", st4, 13'b1_0_0_1_0_0000_0000);
        else n_pass++;
        n_checks++;
        if (imm_data4 !== 16'h0000) $display("FAIL imm_rej_data: got %h want 0000", imm_data4);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b1_0_0_0_0_0000_0000) $display("FAIL imm_rej_n2: got %b want %b", st4, 13'b1_0_0_0_0_0000_0000);
        else n_pass++;
`endif
    endtask

    task automatic test_bad_dst();
        // Rejected by the 3-register instance; the 4-register one moves R0 -> R3.
        issue(2'd0, 2'd3, 1'b0, 16'h0);
        step();
        cmd_valid = 1'b0;
        n_checks++;
        if (st3 !== 11'b1_0_0_1_0_000_000) $display("FAIL bad_dst_n1: got %b want %b", st3, 11'b1_0_0_1_0_000_000);
        else n_pass++;
        step();
        n_checks++;
        if (st3 !== 11'b1_0_0_0_0_000_000) $display("FAIL bad_dst_n2: got %b want %b", st3, 11'b1_0_0_0_0_000_000);
        else n_pass++;
        step(); step();
        n_checks++;
        if (model_regs[3] !== 16'hA5A5) $display("FAIL r0_to_r3_value: got %h want a5a5", model_regs[3]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic        exp_ready;
        logic        exp_done;
        logic [3:0]  exp_out;
        logic [3:0]  exp_in;
        issue(2'd0, 2'd1, 1'b0, 16'h0);
        step();
        for (int k = 1; k <= 8; k++) begin
            exp_ready = (k % 4 == 0);
            exp_done  = (k % 4 == 3);
            exp_out   = ((k % 4 == 1) || (k % 4 == 2)) ? 4'b0001 : 4'b0000;
            exp_in    = (k % 4 == 2) ? 4'b0010 : 4'b0000;
            n_checks++;
            if ({ready4, done4, out_en4, in_en4} !== {exp_ready, exp_done, exp_out, exp_in})
                $display("FAIL b2b_cycle%0d: got %b want %b", k,
                         {ready4, done4, out_en4, in_en4}, {exp_ready, exp_done, exp_out, exp_in});
            else n_pass++;
            if (k == 8) cmd_valid = 1'b0;
            step();
        end
        n_checks++;
        if (model_regs[1] !== 16'hA5A5) $display("FAIL b2b_r1_value: got %h want a5a5", model_regs[1]);
        else n_pass++;
    endtask

    task automatic test_same_reg();
        issue(2'd0, 2'd0, 1'b0, 16'h0);
        step();
        cmd_valid = 1'b0;
        n_checks++;
        if (st4 !== 13'b0_1_0_0_0_0001_0000) $display("FAIL same_n1: got %b want %b", st4, 13'b0_1_0_0_0_0001_0000);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_0_0_0_0001_0000) $display("FAIL same_n2: got %b want %b", st4, 13'b0_1_0_0_0_0001_0000);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_1_0_0_0000_0000) $display("FAIL same_n3: got %b want %b", st4, 13'b0_1_1_0_0_0000_0000);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        issue(2'd1, 2'd2, 1'b0, 16'h0);
        step();
        cmd_valid = 1'b0;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_0_0_0_0010_0100) $display("FAIL mid_latch: got %b want %b", st4, 13'b0_1_0_0_0_0010_0100);
        else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++;
        if (st4 !== 13'b1_0_0_0_0_0000_0000) $display("FAIL mid_after_reset: got %b want %b", st4, 13'b1_0_0_0_0_0000_0000);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (st4 !== 13'b1_0_0_0_0_0000_0000) $display("FAIL mid_no_done: got %b want %b", st4, 13'b1_0_0_0_0_0000_0000);
        else n_pass++;
        issue(2'd2, 2'd0, 1'b0, 16'h0);
        step();
        cmd_valid = 1'b0;
        n_checks++;
        if (st4 !== 13'b0_1_0_0_0_0100_0000) $display("FAIL post_reset_n1: got %b want %b", st4, 13'b0_1_0_0_0_0100_0000);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_0_0_0_0100_0001) $display("FAIL post_reset_n2: got %b want %b", st4, 13'b0_1_0_0_0_0100_0001);
        else n_pass++;
        step();
        n_checks++;
        if (st4 !== 13'b0_1_1_0_0_0000_0000) $display("FAIL post_reset_n3: got %b want %b", st4, 13'b0_1_1_0_0_0000_0000);
        else n_pass++;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_reg_move();
        test_imm();
        test_bad_dst();
        test_back_to_back();
        test_same_reg();
        test_reset_mid();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
